// File: rtl/automata_pkg.sv
// automata_pkg: shared start/config-select encodings and default sizing for the programmable STE engine.
package automata_pkg;
   localparam int N_STE_DEF = 16;
   localparam int SYM_W_DEF = 8;
   localparam int CNT_W_DEF = 32;
   typedef enum logic [1:0] {NONE = 2'd0, SOD = 2'd1, ALL_INPUT = 2'd2} start_type_e;
   typedef enum logic [1:0] {MATCH = 2'd0, EDGE = 2'd1, START = 2'd2, REPORT = 2'd3} cfg_sel_e;
endpackage

// File: rtl/prog_ste_automaton_if.sv
// prog_ste_automaton_if: symbol stream, config port and report outputs of the STE engine.
// AUTOMATA_FIRST_REPORT_EN adds the sticky first-report capture signals.
interface prog_ste_automaton_if #(
   parameter int N_STE = automata_pkg::N_STE_DEF,
   parameter int SYM_W = automata_pkg::SYM_W_DEF,
   parameter int CNT_W = automata_pkg::CNT_W_DEF
);
   localparam int IW = $clog2(N_STE);
   logic run;
   logic restart;
   logic sym_valid;
   logic sym_ready;
   logic [SYM_W-1:0] symbols;
   logic cfg_we;
   logic [1:0] cfg_sel;
   logic [IW-1:0] cfg_ste;
   logic [SYM_W-1:0] cfg_addr;
   logic [1:0] cfg_data;
   logic cfg_err;
   logic [N_STE-1:0] active_vec;
   logic [N_STE-1:0] report_vec;
   logic report_valid;
   logic [CNT_W-1:0] sym_count;
`ifdef AUTOMATA_FIRST_REPORT_EN
   logic first_rpt_valid;
   logic [CNT_W-1:0] first_rpt_pos;
   logic [N_STE-1:0] first_rpt_vec;
   modport master (output run, restart, sym_valid, symbols, cfg_we, cfg_sel, cfg_ste, cfg_addr, cfg_data,
                   input sym_ready, cfg_err, active_vec, report_vec, report_valid, sym_count,
                   first_rpt_valid, first_rpt_pos, first_rpt_vec);
   modport slave (input run, restart, sym_valid, symbols, cfg_we, cfg_sel, cfg_ste, cfg_addr, cfg_data,
                  output sym_ready, cfg_err, active_vec, report_vec, report_valid, sym_count,
                  first_rpt_valid, first_rpt_pos, first_rpt_vec);
`else
   modport master (output run, restart, sym_valid, symbols, cfg_we, cfg_sel, cfg_ste, cfg_addr, cfg_data,
                   input sym_ready, cfg_err, active_vec, report_vec, report_valid, sym_count);
   modport slave (input run, restart, sym_valid, symbols, cfg_we, cfg_sel, cfg_ste, cfg_addr, cfg_data,
                  output sym_ready, cfg_err, active_vec, report_vec, report_valid, sym_count);
`endif
endinterface

// File: rtl/ste_match_bank.sv
// ste_match_bank: one STE's 2^SYM_W-bit symbol match bitmap with a write port and combinational lookup.
module ste_match_bank #(
   parameter int SYM_W = automata_pkg::SYM_W_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic we,
   input  logic [SYM_W-1:0] addr,
   input  logic data,
   input  logic [SYM_W-1:0] symbols,
   output logic match
);
   logic [2**SYM_W-1:0] bits;
   always_ff @(posedge clk)
      if (!reset) bits <= '0;
      else if (we) bits[addr] <= data;
   assign match = bits[symbols];
endmodule

// File: rtl/prog_ste_automaton.sv
// prog_ste_automaton: run-time programmable homogeneous automaton (match bitmaps, adjacency, start types, report mask).
// AUTOMATA_FIRST_REPORT_EN adds sticky capture of the first report position and vector.
module prog_ste_automaton import automata_pkg::*; #(
   parameter int N_STE = N_STE_DEF,
   parameter int SYM_W = SYM_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input logic clk,
   input logic reset,
   prog_ste_automaton_if.slave bus
);
   localparam int IW = $clog2(N_STE);
   logic [N_STE-1:0] active, match, en, nxt, rmask;
   logic [N_STE-1:0] edges [N_STE];
   start_type_e st [N_STE];
   logic sod, accept, cfg_ok, rv, err;
   logic [CNT_W-1:0] cnt;
   cfg_sel_e sel;
   logic [IW-1:0] src;
   assign sel = cfg_sel_e'(bus.cfg_sel);
   assign src = bus.cfg_addr[IW-1:0];
   assign bus.sym_ready = bus.run && !bus.restart;
   assign accept = bus.sym_valid && bus.sym_ready;
   assign cfg_ok = bus.cfg_we && !bus.run && int'(bus.cfg_ste) < N_STE &&
                   !(sel == EDGE && int'(bus.cfg_addr) >= N_STE);
   for (genvar g = 0; g < N_STE; g++) begin : g_bank
      ste_match_bank #(.SYM_W(SYM_W)) u_bank (
         .clk(clk),
         .reset(reset),
         .we(cfg_ok && sel == MATCH && bus.cfg_ste == IW'(g)),
         .addr(bus.cfg_addr),
         .data(bus.cfg_data[0]),
         .symbols(bus.symbols),
         .match(match[g])
      );
   end
   // edges[j][i]: an active source j enables destination i on the next symbol
   always_comb begin
      en = '0;
      for (int i = 0; i < N_STE; i++) begin
         en[i] = st[i] == ALL_INPUT || (st[i] == SOD && sod);
         for (int j = 0; j < N_STE; j++) en[i] = en[i] || (active[j] && edges[j][i]);
      end
      nxt = en & match;
   end
   always_ff @(posedge clk)
      if (!reset) begin
         for (int i = 0; i < N_STE; i++) begin
            edges[i] <= '0;
            st[i] <= NONE;
         end
         rmask <= '0;
      end else if (cfg_ok) begin
         if (sel == EDGE) edges[src][bus.cfg_ste] <= bus.cfg_data[0];
         if (sel == START) st[bus.cfg_ste] <= start_type_e'(bus.cfg_data);
         if (sel == REPORT) rmask[bus.cfg_ste] <= bus.cfg_data[0];
      end
   always_ff @(posedge clk)
      if (!reset) begin
         active <= '0;
         sod <= 1'b1;
         cnt <= '0;
         rv <= 1'b0;
         err <= 1'b0;
      end else begin
         err <= bus.cfg_we && !cfg_ok;
         rv <= accept && |(nxt & rmask);
         if (bus.restart) begin
            active <= '0;
            sod <= 1'b1;
            cnt <= '0;
         end else if (accept) begin
            active <= nxt;
            sod <= 1'b0;
            cnt <= &cnt ? cnt : cnt + CNT_W'(1);
         end
      end
   assign bus.cfg_err = err;
   assign bus.active_vec = active;
   assign bus.report_vec = active & rmask;
   assign bus.report_valid = rv;
   assign bus.sym_count = cnt;
`ifdef AUTOMATA_FIRST_REPORT_EN
   logic frv;
   logic [CNT_W-1:0] fpos;
   logic [N_STE-1:0] fvec;
   // cnt still holds the pre-increment value, i.e. the 0-based index of the reporting symbol
   always_ff @(posedge clk)
      if (!reset || bus.restart) begin
         frv <= 1'b0;
         fpos <= '0;
         fvec <= '0;
      end else if (accept && |(nxt & rmask) && !frv) begin
         frv <= 1'b1;
         fpos <= cnt;
         fvec <= nxt & rmask;
      end
   assign bus.first_rpt_valid = frv;
   assign bus.first_rpt_pos = fpos;
   assign bus.first_rpt_vec = fvec;
`endif
endmodule

// File: tb/tb_prog_ste_automaton.sv
// tb_prog_ste_automaton: set-based NFA reference model checked every cycle plus directed literal expectations.
module tb_prog_ste_automaton;
   localparam int N = 16;
   localparam int SW = 8;
   localparam int CW = 32;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;
   prog_ste_automaton_if #(.N_STE(N), .SYM_W(SW), .CNT_W(CW)) bus ();
   prog_ste_automaton #(.N_STE(N), .SYM_W(SW), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
   int errors = 0;
   int checks = 0;
   bit chk_on = 0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // reference model: active set is (successors of active set | enabled starts) & states matching the symbol
   bit [255:0] m_match [N];
   bit [N-1:0] m_edge [N];
   int m_start [N];
   bit [N-1:0] m_rep, m_act, m_fvec, m_succ, m_allow, m_hit;
   bit m_sod = 1, m_rv, m_err, m_frv, m_bad;
   longint m_cnt, m_fpos;
   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) begin
            m_match[i] = '0;
            m_edge[i] = '0;
            m_start[i] = 0;
         end
         m_rep = 0; m_act = 0; m_sod = 1; m_cnt = 0; m_rv = 0; m_err = 0;
         m_frv = 0; m_fpos = 0; m_fvec = 0;
      end else begin
         m_bad = bus.run || (bus.cfg_sel == 2'd1 && int'(bus.cfg_addr) >= N);
         m_err = bus.cfg_we && m_bad;
         if (bus.cfg_we && !m_bad)
            case (bus.cfg_sel)
               2'd0: m_match[bus.cfg_ste][bus.cfg_addr] = bus.cfg_data[0];
               2'd1: m_edge[bus.cfg_addr][bus.cfg_ste] = bus.cfg_data[0];
               2'd2: m_start[bus.cfg_ste] = int'(bus.cfg_data);
               default: m_rep[bus.cfg_ste] = bus.cfg_data[0];
            endcase
         m_rv = 0;
         if (bus.restart) begin
            m_act = 0; m_sod = 1; m_cnt = 0; m_frv = 0; m_fpos = 0; m_fvec = 0;
         end else if (bus.run && bus.sym_valid) begin
            m_succ = 0; m_allow = 0; m_hit = 0;
            for (int j = 0; j < N; j++) if (m_act[j]) m_succ |= m_edge[j];
            for (int i = 0; i < N; i++) begin
               m_allow[i] = m_start[i] == 2 || (m_start[i] == 1 && m_sod);
               m_hit[i] = m_match[i][bus.symbols];
            end
            m_act = (m_succ | m_allow) & m_hit;
            m_rv = |(m_act & m_rep);
            if (m_rv && !m_frv) begin
               m_frv = 1; m_fpos = m_cnt; m_fvec = m_act & m_rep;
            end
            m_sod = 0;
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
         end
      end
   end
   always @(negedge clk)
      if (chk_on) begin
         chk("active_vec", bus.active_vec, m_act);
         chk("report_vec", bus.report_vec, m_act & m_rep);
         chk("report_valid", bus.report_valid, m_rv);
         chk("sym_count", bus.sym_count, m_cnt);
         chk("cfg_err", bus.cfg_err, m_err);
         chk("sym_ready", bus.sym_ready, bus.run && !bus.restart);
`ifdef AUTOMATA_FIRST_REPORT_EN
         chk("first_rpt_valid", bus.first_rpt_valid, m_frv);
         chk("first_rpt_pos", bus.first_rpt_pos, m_fpos);
         chk("first_rpt_vec", bus.first_rpt_vec, m_fvec);
`endif
      end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [7:0] s);
      bus.sym_valid = 1'b1;
      bus.symbols = s;
      step();
      bus.sym_valid = 1'b0;
   endtask
   task automatic cfg(input logic [1:0] sel, input logic [3:0] ste, input logic [7:0] addr, input logic [1:0] data);
      bus.cfg_we = 1'b1;
      bus.cfg_sel = sel;
      bus.cfg_ste = ste;
      bus.cfg_addr = addr;
      bus.cfg_data = data;
      step();
      bus.cfg_we = 1'b0;
   endtask
   task automatic do_reset();
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask
   task automatic do_restart();
      bus.restart = 1'b1;
      step();
      bus.restart = 1'b0;
   endtask
   int rv_seen;
   initial begin
      bus.run = 0; bus.restart = 0; bus.sym_valid = 0; bus.symbols = 0;
      bus.cfg_we = 0; bus.cfg_sel = 0; bus.cfg_ste = 0; bus.cfg_addr = 0; bus.cfg_data = 0;
      step();
      step();
      chk_on = 1;
      reset = 1'b1;
      chk("rst active_vec", bus.active_vec, 0);
      chk("rst sym_count", bus.sym_count, 0);
      chk("rst report_valid", bus.report_valid, 0);
      chk("rst cfg_err", bus.cfg_err, 0);
      // unconfigured engine never activates
      bus.run = 1;
      rv_seen = 0;
      for (int s = 0; s < 256; s++) begin
         send(8'(s));
         if (bus.report_valid) rv_seen++;
      end
      chk("empty sym_count", bus.sym_count, 256);
      chk("empty active", bus.active_vec, 0);
      chk("empty reports", rv_seen, 0);
      // single SOD state matching 'A'
      bus.run = 0;
      do_restart();
      cfg(2, 0, 0, 1);
      cfg(0, 0, 8'h41, 1);
      cfg(3, 0, 0, 1);
      bus.run = 1;
      send(8'h41);
      chk("sod first report_vec", bus.report_vec, 1);
      chk("sod first report_valid", bus.report_valid, 1);
      step();
      chk("sod idle report_valid", bus.report_valid, 0);
      chk("sod idle hold report_vec", bus.report_vec, 1);
      send(8'h41);
      chk("sod second report_vec", bus.report_vec, 0);
      // chain STE0 (0..7, self loop) -> STE1 (0x08)
      do_reset();
      bus.run = 0;
      cfg(2, 0, 0, 1);
      for (int s = 0; s < 8; s++) cfg(0, 0, 8'(s), 1);
      cfg(1, 0, 0, 1);
      cfg(0, 1, 8'h08, 1);
      cfg(1, 1, 0, 1);
      cfg(3, 1, 0, 1);
      bus.run = 1;
      send(8'h03);
      chk("chain s1 active", bus.active_vec, 1);
      bus.run = 0;
      step();
      bus.run = 1;
      send(8'h05);
      chk("chain s2 report_valid", bus.report_valid, 0);
      send(8'h08);
      chk("chain s3 report_valid", bus.report_valid, 1);
      chk("chain s3 report_vec", bus.report_vec, 2);
      chk("chain sym_count", bus.sym_count, 3);
      // all-input STE2 matching 0xFF
      do_reset();
      bus.run = 0;
      cfg(2, 2, 0, 2);
      cfg(0, 2, 8'hFF, 1);
      cfg(3, 2, 0, 1);
      bus.run = 1;
      send(8'h00);
      chk("all s1 report_valid", bus.report_valid, 0);
      send(8'hFF);
      chk("all s2 report_valid", bus.report_valid, 1);
      chk("all s2 report_vec", bus.report_vec, 4);
      send(8'h10);
      chk("all s3 report_valid", bus.report_valid, 0);
      send(8'hFF);
      chk("all s4 report_valid", bus.report_valid, 1);
      // rejected config writes
      cfg(0, 2, 8'h10, 1);
      chk("run write cfg_err", bus.cfg_err, 1);
      step();
      chk("cfg_err pulse end", bus.cfg_err, 0);
      send(8'h10);
      chk("table unchanged", bus.report_valid, 0);
      bus.run = 0;
      cfg(1, 0, 8'd20, 1);
      chk("bad edge cfg_err", bus.cfg_err, 1);
      // restart with a symbol pending re-arms start-of-data
      cfg(2, 0, 0, 1);
      cfg(0, 0, 8'h41, 1);
      cfg(3, 0, 0, 1);
      do_restart();
      bus.run = 1;
      send(8'h41);
      chk("pre restart report_vec", bus.report_vec, 1);
      bus.restart = 1;
      bus.sym_valid = 1;
      bus.symbols = 8'h41;
      #1;
      chk("restart sym_ready", bus.sym_ready, 0);
      step();
      bus.restart = 0;
      bus.sym_valid = 0;
      chk("restart active", bus.active_vec, 0);
      chk("restart sym_count", bus.sym_count, 0);
      send(8'h41);
      chk("rearm report_vec", bus.report_vec, 1);
      chk("rearm report_valid", bus.report_valid, 1);
`ifdef AUTOMATA_FIRST_REPORT_EN
      do_reset();
      bus.run = 0;
      cfg(2, 0, 0, 1);
      cfg(0, 0, 8'h41, 1);
      cfg(0, 0, 8'h00, 1);
      cfg(0, 0, 8'h00, 0);
      cfg(3, 0, 0, 1);
      bus.run = 1;
      send(8'h00);
      send(8'h00);
      send(8'h41);
      chk("first valid", bus.first_rpt_valid, 0);
      do_restart();
      send(8'h41);
      chk("first valid sod", bus.first_rpt_valid, 1);
      chk("first pos sod", bus.first_rpt_pos, 0);
      do_reset();
      bus.run = 0;
      cfg(2, 0, 0, 2);
      cfg(0, 0, 8'h41, 1);
      cfg(3, 0, 0, 1);
      bus.run = 1;
      send(8'h00);
      send(8'h00);
      send(8'h41);
      chk("first valid", bus.first_rpt_valid, 1);
      chk("first pos", bus.first_rpt_pos, 2);
      chk("first vec", bus.first_rpt_vec, 1);
      send(8'h41);
      chk("first pos held", bus.first_rpt_pos, 2);
      chk("first vec held", bus.first_rpt_vec, 1);
      do_restart();
      chk("first cleared", bus.first_rpt_valid, 0);
      chk("first pos cleared", bus.first_rpt_pos, 0);
`endif
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/prog_ste_automaton.md
# prog_ste_automaton

Run-time programmable homogeneous automaton engine for the RM monitor clusters. It generalises the per-property, hard-wired STE netlists into a single block with N_STE states: per-state symbol match bitmaps, a transition adjacency matrix, start types and report masks are all loaded through a config port. It consumes one SYM_W-bit symbol per accepted handshake and produces a registered report vector, so one instance can host any monitor property up to N_STE states.

## Interface
- N_STE, 16: number of STEs (2..64).
- SYM_W, 8: symbol width; each match bitmap holds 2^SYM_W bits.
- CNT_W, 32: width of the accepted-symbol counter.
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low: reset=0 at posedge resets the block.
- run  in  1  1 = evaluate symbols; 0 = configuration allowed.
- restart  in  1  one-cycle pulse: clear active states, re-arm start-of-data.
- sym_valid  in  1  symbol present.
- sym_ready  out  1  = run & ~restart.
- symbols  in  SYM_W  input symbol.
- cfg_we  in  1  config write strobe.
- cfg_sel  in  2  0 match bit, 1 edge bit, 2 start type, 3 report bit.
- cfg_ste  in  $clog2(N_STE)  target STE.
- cfg_addr  in  SYM_W  symbol (sel 0), source STE (sel 1), else ignored.
- cfg_data  in  2  bit 0 = value (sel 0/1/3); [1:0] = start type (sel 2).
- cfg_err  out  1  pulses when a write is rejected.
- active_vec  out  N_STE  registered active states.
- report_vec  out  N_STE  active_vec & report mask.
- report_valid  out  1  |report_vec, one-cycle pulse per accepted symbol.
- sym_count  out  CNT_W  accepted symbols since the last restart or reset.

## Operation
- Start types: 0 = none, 1 = start-of-data (enabled only for the first accepted symbol after reset or restart), 2 = all-input (enabled on every accepted symbol).
- Accept = sym_valid & sym_ready. On accept: enable_i = start_en_i | OR_j(active_j & edge[j][i]); active_i <= enable_i & match_i[symbols]. After the first accept, sod clears.
- No accept: active_vec, sod and sym_count hold. report_valid drops to 0.
- restart=1: active_vec <= 0, sod <= 1, sym_count <= 0, report_valid <= 0. Any symbol presented in that cycle is not consumed (sym_ready=0).
- Config write is applied only when run=0. If cfg_we=1 while run=1, or cfg_sel=1 with cfg_addr >= N_STE, or cfg_ste >= N_STE, the write is dropped and cfg_err pulses 1 for one cycle.
- Config tables are not cleared by restart.
- sym_count saturates at all-ones.
- Dropping run mid-stream freezes state; raising it again resumes without re-arming sod.

## Timing
- Reset values: active_vec, report_vec, report_valid, sym_count, cfg_err all 0; sod=1. All match bitmaps, edges, start types and report masks are 0.
- Latency: symbol accepted at edge k → active_vec/report_vec/report_valid valid after edge k, i.e. one cycle.
- Config write at edge k is visible to a symbol accepted at edge k+1.
- Reset asserted mid-stream discards state and config in the same edge.

## Configuration
- AUTOMATA_FIRST_REPORT_EN defined: adds outputs first_rpt_valid (1), first_rpt_pos (CNT_W) and first_rpt_vec (N_STE).
  - On the first report_valid after reset or restart, these capture sym_count (the index of the reporting symbol, 0-based) and report_vec, and first_rpt_valid is set.
  - The captured values are sticky until restart or reset, which clear them to 0.
- Undefined: these ports and their registers are absent.

## Structure
- Package automata_pkg holds:
  - typedef start_type_e (NONE, SOD, ALL_INPUT);
  - typedef cfg_sel_e (MATCH, EDGE, START, REPORT);
  - default parameter constants.
- Sub-module ste_match_bank, one per STE: a 2^SYM_W-bit bitmap with a write port and a combinational lookup of symbols. The adjacency matrix and the active register stay in the top.

## Test plan
- Reset, then with no config apply run=1 and symbols 0x00..0xFF → active_vec=0, report_valid never set, sym_count=256.
- STE0 configured SOD, match 0x41, report; send 0x41,0x41 → report_vec=0x1 after the first symbol only; second cycle report_vec=0.
- Chain STE0(SOD, match 0x00..0x07, self-loop) → STE1(match 0x08, report); send 0x03,0x05,0x08 → report_valid pulses on the third symbol; sym_count=3.
- STE2 ALL_INPUT, match 0xFF, report; send 0x00,0xFF,0x10,0xFF → report_valid on symbols 2 and 4.
- Config write with run=1 → cfg_err=1 for one cycle and the table is unchanged. Restart together with sym_valid=1 → sym_ready=0, active_vec=0 and sod re-armed, so the next 0x41 reports again.
- AUTOMATA_FIRST_REPORT_EN: the single-STE 0x41 setup, send 0x00,0x00,0x41,0x41 → first_rpt_pos=2, first_rpt_vec=0x1; both are held through the 4th symbol and cleared by restart.
